// File: rtl/operand_forward_unit.sv
// EX-stage operand bypass: picks each operand from MEM, WB, a retired-write history or the register file.
// Optional build macro FWD_STATS_EN adds saturating forward-hit and load-stall counters.
module operand_forward_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_OPS = 2,
    parameter int DEPTH   = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_OPS*ADDR_W-1:0]   ex_src_addr,
    input  logic [NUM_OPS*DATA_W-1:0]   ex_reg_data,
    input  logic                        mem_wr_en,
    input  logic [ADDR_W-1:0]           mem_wr_addr,
    input  logic                        mem_is_load,
    input  logic [DATA_W-1:0]           mem_alu_data,
    input  logic [DATA_W-1:0]           mem_rd_data,
    input  logic                        mem_rd_valid,
    input  logic                        wb_wr_en,
    input  logic [ADDR_W-1:0]           wb_wr_addr,
    input  logic [DATA_W-1:0]           wb_data,
    input  logic                        hist_flush,
    output logic [NUM_OPS*DATA_W-1:0]   ex_op_data,
    output logic [NUM_OPS*3-1:0]        fwd_src,
    output logic                        load_stall
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]                 fwd_hit_cnt,
    output logic [31:0]                 stall_cnt
`endif
);

    logic [DEPTH-1:0][ADDR_W-1:0] hist_addr_q,  hist_addr_d;
    logic [DEPTH-1:0][DATA_W-1:0] hist_data_q,  hist_data_d;
    logic [DEPTH-1:0]             hist_valid_q, hist_valid_d;

    logic [NUM_OPS-1:0] op_stall;
    logic               wb_commit;

    assign wb_commit = wb_wr_en && (wb_wr_addr != '0);

    // History only moves on a real retired write; a flush clears every older entry.
    always_comb begin
        hist_addr_d  = hist_addr_q;
        hist_data_d  = hist_data_q;
        hist_valid_d = hist_flush ? '0 : hist_valid_q;
        if (wb_commit) begin
            for (int k = 1; k < DEPTH; k++) begin
                hist_addr_d[k]  = hist_addr_q[k-1];
                hist_data_d[k]  = hist_data_q[k-1];
                hist_valid_d[k] = hist_valid_q[k-1] && !hist_flush;
            end
            hist_addr_d[0]  = wb_wr_addr;
            hist_data_d[0]  = wb_data;
            hist_valid_d[0] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_addr_q  <= '0;
            hist_data_q  <= '0;
            hist_valid_q <= '0;
        end else begin
            hist_addr_q  <= hist_addr_d;
            hist_data_q  <= hist_data_d;
            hist_valid_q <= hist_valid_d;
        end
    end

    always_comb begin
        ex_op_data = ex_reg_data;
        fwd_src    = '0;
        op_stall   = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            logic [ADDR_W-1:0] src;
            logic              found;
            src   = ex_src_addr[i*ADDR_W +: ADDR_W];
            found = 1'b0;
            if (src != '0) begin
                if (mem_wr_en && mem_wr_addr == src) begin
                    fwd_src[i*3 +: 3]          = 3'd1;
                    ex_op_data[i*DATA_W +: DATA_W] = mem_is_load ? mem_rd_data : mem_alu_data;
                    op_stall[i]                = mem_is_load && !mem_rd_valid;
                end else if (wb_wr_en && wb_wr_addr == src) begin
                    fwd_src[i*3 +: 3]          = 3'd2;
                    ex_op_data[i*DATA_W +: DATA_W] = wb_data;
                end else begin
                    // Index 0 is newest, so the first valid hit is the most recent write.
                    for (int k = 0; k < DEPTH; k++) begin
                        if (!found && hist_valid_q[k] && hist_addr_q[k] == src) begin
                            found                      = 1'b1;
                            fwd_src[i*3 +: 3]          = 3'(k + 3);
                            ex_op_data[i*DATA_W +: DATA_W] = hist_data_q[k];
                        end
                    end
                end
            end
        end
    end

    assign load_stall = |op_stall;

`ifdef FWD_STATS_EN
    logic [31:0] fwd_hit_cnt_q, fwd_hit_cnt_d;
    logic [31:0] stall_cnt_q,   stall_cnt_d;
    logic        any_fwd;

    assign any_fwd = |fwd_src;

    always_comb begin
        fwd_hit_cnt_d = fwd_hit_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        if (any_fwd && !load_stall && fwd_hit_cnt_q != 32'hFFFF_FFFF)
            fwd_hit_cnt_d = fwd_hit_cnt_q + 32'd1;
        if (load_stall && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_hit_cnt_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            fwd_hit_cnt_q <= fwd_hit_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign fwd_hit_cnt = fwd_hit_cnt_q;
    assign stall_cnt   = stall_cnt_q;
`endif

endmodule
